// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: multi-cycle RV32I load/store data memory behind a
// Req/Ready handshake, with WAIT_STATES extra cycles per access.
// Optional build macro MISALIGN_TRAP_EN: flags misaligned half/word accesses
// on Misaligned and suppresses their effect (no write, ReadData=0).
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Write,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Misaligned
);

  localparam int         DEPTH     = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    mis_q, mis_d;

  logic [31:0]             mem_q [DEPTH];

  // Effective access: live inputs while IDLE (zero-wait path), captured copy afterwards
  logic                    acc_write_s;
  logic [2:0]              acc_f3_s;
  logic [ADDR_WIDTH-1:0]   acc_addr_s;
  logic [31:0]             acc_wdata_s;
  logic [ADDR_WIDTH-3:0]   acc_idx_s;
  logic [1:0]              acc_lane_s;
  logic [31:0]             word_s;
  logic [31:0]             load_s;
  logic [31:0]             store_s;
  logic                    mis_s;
  logic                    commit_s;
  logic                    unused_addr_s;

  // Address bits above the decoded range alias and are deliberately dropped
  assign unused_addr_s = ^Addr[31:ADDR_WIDTH];

  // Select the requested byte/half/word and sign- or zero-extend it
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = word;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  // Merge the low bits of the store data into the selected lanes only
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000, 3'b100: r[{lane, 3'b000} +: 8] = wdata[7:0];
      3'b001, 3'b101: begin
        if (lane[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      3'b010:  r = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  // Half accesses need an even address, word accesses a 4-byte aligned one
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic m;
    case (f3)
      3'b001, 3'b101: m = lane[0];
      3'b010:         m = (lane != 2'b00);
      default:        m = 1'b0;
    endcase
    return m;
  endfunction
`endif

  // Form the effective access and the load/store data it would produce
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write_s = Write;
      acc_f3_s    = Funct3;
      acc_addr_s  = Addr[ADDR_WIDTH-1:0];
      acc_wdata_s = WriteData;
    end else begin
      acc_write_s = write_q;
      acc_f3_s    = funct3_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
    end
    acc_idx_s  = acc_addr_s[ADDR_WIDTH-1:2];
    acc_lane_s = acc_addr_s[1:0];
    word_s     = mem_q[acc_idx_s];
`ifdef MISALIGN_TRAP_EN
    mis_s      = is_misaligned(acc_f3_s, acc_lane_s);
`else
    mis_s      = 1'b0;
`endif
    if (mis_s) begin
      load_s  = 32'h00000000;
      store_s = word_s;
    end else begin
      load_s  = load_extract(word_s, acc_f3_s, acc_lane_s);
      store_s = store_merge(word_s, acc_wdata_s, acc_f3_s, acc_lane_s);
    end
  end

  // Next-state logic: capture in IDLE, count down in WAIT, one DONE cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          write_d  = Write;
          funct3_d = Funct3;
          addr_d   = Addr[ADDR_WIDTH-1:0];
          wdata_d  = WriteData;
          if (WAIT_STATES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Commit happens on the edge that enters DONE; outputs are registered there
  always_comb begin
    commit_s = (state_d == S_DONE) && (state_q != S_DONE);
    ready_d  = commit_s;
    rdata_d  = rdata_q;
    mis_d    = 1'b0;
    if (commit_s) begin
      rdata_d = acc_write_s ? 32'h00000000 : load_s;
      mis_d   = mis_s;
    end else begin
      mis_d   = 1'b0;
    end
  end

  // State, captured request and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h00000000;
      rdata_q  <= 32'h00000000;
      ready_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      mis_q    <= mis_d;
    end
  end

  // Memory array (not reset); a store is blocked while Reset is held
  always_ff @(posedge Clk) begin
    if (!Reset && commit_s && acc_write_s) begin
      mem_q[acc_idx_s] <= store_s;
    end
  end

  assign Busy       = ((state_q == S_IDLE) && Req) || (state_q == S_WAIT);
  assign ReadData   = rdata_q;
  assign Ready      = ready_q;
  assign Misaligned = mis_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: byte-addressed reference model,
// per-cycle compare on the WAIT_STATES=2 instance, directed checks on a
// WAIT_STATES=0 instance and on reset behaviour.
module tb_data_memory_ctrl;

  localparam int WS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WAIT_STATES=2 instance
  logic        rst2 = 1'b1, req2 = 1'b0, wr2 = 1'b0;
  logic [2:0]  f32 = 3'b000;
  logic [31:0] addr2 = 32'h0, wd2 = 32'h0, rd2;
  logic        ready2, busy2, mis2;

  // WAIT_STATES=0 instance
  logic        rst0 = 1'b1, req0 = 1'b0, wr0 = 1'b0;
  logic [2:0]  f30 = 3'b000;
  logic [31:0] addr0 = 32'h0, wd0 = 32'h0, rd0;
  logic        ready0, busy0, mis0;

  data_memory_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut2 (
    .Clk(clk), .Reset(rst2), .Req(req2), .Write(wr2), .Funct3(f32),
    .Addr(addr2), .WriteData(wd2), .ReadData(rd2), .Ready(ready2),
    .Busy(busy2), .Misaligned(mis2)
  );

  data_memory_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .Clk(clk), .Reset(rst0), .Req(req0), .Write(wr0), .Funct3(f30),
    .Addr(addr0), .WriteData(wd0), .ReadData(rd0), .Ready(ready0),
    .Busy(busy0), .Misaligned(mis0)
  );

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  model_mem [0:1023];
  int          busy_start = -100;
  logic [31:0] pend_rd = 32'h0;
  logic        pend_mis = 1'b0;
  logic [31:0] held_rd = 32'h0;
  bit          chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte memory, size from funct3, aligned base, extension by funct3[2]
  task automatic model_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] r, output logic m);
    int nb;
    int base;
    int a10;
    a10 = int'(a & 32'h3FF);
    case (f3)
      3'b000, 3'b100: nb = 1;
      3'b001, 3'b101: nb = 2;
      3'b010:         nb = 4;
      default:        nb = 0;
    endcase
    m = 1'b0;
    r = 32'h0;
`ifdef MISALIGN_TRAP_EN
    if (nb > 1 && (a10 % nb) != 0) m = 1'b1;
`endif
    if (nb > 0 && !m) begin
      base = a10 - (a10 % nb);
      for (int i = 0; i < nb; i++) begin
        if (w) model_mem[base + i] = d[8*i +: 8];
        else   r[8*i +: 8] = model_mem[base + i];
      end
      if (!w && f3[2] == 1'b0 && nb < 4 && r[8*nb-1]) begin
        for (int i = nb; i < 4; i++) r[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  // Per-cycle compare of the WAIT_STATES=2 instance against the model's timeline
  always @(negedge clk) begin
    if (rst2) begin
      held_rd <= 32'h0;
    end else if (chk_en) begin
      check("busy", 32'(busy2), 32'((cyc >= busy_start) && (cyc <= busy_start + WS)));
      check("ready", 32'(ready2), 32'(cyc == busy_start + WS + 1));
      if (cyc == busy_start + WS + 1) begin
        check("rdata_done", rd2, pend_rd);
        check("mis_done", 32'(mis2), 32'(pend_mis));
        held_rd <= pend_rd;
      end else begin
        check("rdata_hold", rd2, held_rd);
        check("mis_idle", 32'(mis2), 32'd0);
      end
    end
  end

  task automatic do_acc(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    logic [31:0] r;
    logic        m;
    @(posedge clk); #1;
    model_access(w, f3, a, d, r, m);
    pend_rd    = r;
    pend_mis   = m;
    busy_start = cyc;
    req2 = 1'b1; wr2 = w; f32 = f3; addr2 = a; wd2 = d;
    @(posedge clk); #1;
    req2 = 1'b0;
    repeat (WS + 1) @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string nm, input logic [31:0] lit);
    check(nm, rd2, lit);
    check({nm, "_model"}, pend_rd, lit);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rd2, 32'h0);
    check("rst_ready", 32'(ready2), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_mis", 32'(mis2), 32'd0);
    check("rst0_ready", 32'(ready0), 32'd0);
    check("rst0_rdata", rd0, 32'h0);
    rst2 = 1'b0;
    rst0 = 1'b0;
    chk_en = 1'b1;

    // Word store/load round trip
    do_acc(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    expect_rd("t1_sw_rdata", 32'h0);
    do_acc(1'b0, 3'b010, 32'h10, 32'h0);
    expect_rd("t1_lw", 32'hDEADBEEF);

    // Byte lane store and signed/unsigned byte loads
    do_acc(1'b1, 3'b010, 32'h10, 32'h11223344);
    do_acc(1'b1, 3'b000, 32'h13, 32'h000000A5);
    do_acc(1'b0, 3'b010, 32'h10, 32'h0);
    expect_rd("t2_lw", 32'hA5223344);
    do_acc(1'b0, 3'b000, 32'h13, 32'h0);
    expect_rd("t2_lb", 32'hFFFFFFA5);
    do_acc(1'b0, 3'b100, 32'h13, 32'h0);
    expect_rd("t2_lbu", 32'h000000A5);
    do_acc(1'b0, 3'b010, 32'h410, 32'h0);
    expect_rd("t2_alias", 32'hA5223344);

    // Half lane store, half loads, unsupported funct3
    do_acc(1'b1, 3'b010, 32'h20, 32'h0);
    do_acc(1'b1, 3'b001, 32'h22, 32'h00008001);
    do_acc(1'b0, 3'b010, 32'h20, 32'h0);
    expect_rd("t3_lw", 32'h80010000);
    do_acc(1'b0, 3'b001, 32'h22, 32'h0);
    expect_rd("t3_lh", 32'hFFFF8001);
    do_acc(1'b0, 3'b101, 32'h22, 32'h0);
    expect_rd("t3_lhu", 32'h00008001);
    do_acc(1'b0, 3'b011, 32'h20, 32'h0);
    expect_rd("t3_f3_011", 32'h0);
    do_acc(1'b1, 3'b111, 32'h20, 32'hFFFFFFFF);
    do_acc(1'b0, 3'b010, 32'h20, 32'h0);
    expect_rd("t3_bad_store", 32'h80010000);

    // Misaligned word load
    do_acc(1'b1, 3'b010, 32'h00, 32'hCAFEF00D);
    do_acc(1'b0, 3'b010, 32'h02, 32'h0);
`ifdef MISALIGN_TRAP_EN
    expect_rd("t6_lw_mis", 32'h0);
    check("t6_model_mis", 32'(pend_mis), 32'd1);
`else
    expect_rd("t6_lw_nomis", 32'hCAFEF00D);
    check("t6_model_mis", 32'(pend_mis), 32'd0);
`endif

    // Reset during WAIT aborts the store
    @(posedge clk); #1;
    chk_en = 1'b0;
    req2 = 1'b1; wr2 = 1'b1; f32 = 3'b010; addr2 = 32'h30; wd2 = 32'h12345678;
    @(posedge clk); #1;
    req2 = 1'b0;
    check("t5_busy_wait", 32'(busy2), 32'd1);
    rst2 = 1'b1;
    #1;
    check("t5_busy_drop", 32'(busy2), 32'd0);
    check("t5_ready_rst", 32'(ready2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_ready", 32'(ready2), 32'd0);
    end
    @(posedge clk); #1;
    rst2 = 1'b0;
    busy_start = -100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_ready_after", 32'(ready2), 32'd0);
      check("t5_idle_busy", 32'(busy2), 32'd0);
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_acc(1'b0, 3'b010, 32'h30, 32'h0);
    expect_rd("t5_lw_after_abort", 32'h0);

    // Zero-wait instance, Req held across two loads
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b1; f30 = 3'b010; addr0 = 32'h40; wd0 = 32'h0BADCAFE;
    @(negedge clk);
    check("t4_sw_busy", 32'(busy0), 32'd1);
    check("t4_sw_noready", 32'(ready0), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("t4_sw_ready", 32'(ready0), 32'd1);
    check("t4_sw_busy_done", 32'(busy0), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b0;
    @(negedge clk);
    check("t4_lw1_busy", 32'(busy0), 32'd1);
    check("t4_lw1_noready", 32'(ready0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t4_lw1_ready", 32'(ready0), 32'd1);
    check("t4_lw1_busy_done", 32'(busy0), 32'd0);
    check("t4_lw1_rdata", rd0, 32'h0BADCAFE);
    check("t4_lw1_mis", 32'(mis0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t4_lw2_busy", 32'(busy0), 32'd1);
    check("t4_lw2_noready", 32'(ready0), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("t4_lw2_ready", 32'(ready0), 32'd1);
    check("t4_lw2_busy_done", 32'(busy0), 32'd0);
    check("t4_lw2_rdata", rd0, 32'h0BADCAFE);
    @(negedge clk);
    check("t4_ready_one_cycle", 32'(ready0), 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
